context_sched: RTL and testbench



---
 rtl/loco_pkg.sv | 56 +++++
 rtl/context_sched_if.sv | 44 ++++
 rtl/ctx_fwd.sv | 36 +++
 rtl/context_sched.sv | 137 +++++++++++++
 tb/tb_context_sched.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loco_pkg.sv
// Shared definitions for the context scheduler: field widths, RAM word layout,
// pack/unpack helpers and the scheduler FSM encoding.
package loco_pkg;

    localparam int A_W     = 13;
    localparam int B_W     = 7;
    localparam int C_W     = 8;
    localparam int N_W     = 7;
    localparam int Q_W     = 9;
    localparam int NUM_CTX = 365;
    localparam int A_INIT  = 4;
    localparam int RAM_W   = A_W + B_W + C_W + N_W;

    // Field offsets inside a RAM word {A,B,C,N}
    localparam int N_LSB = 0;
    localparam int C_LSB = N_LSB + N_W;
    localparam int B_LSB = C_LSB + C_W;
    localparam int A_LSB = B_LSB + B_W;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [C_W-1:0] c;
        logic [N_W-1:0] n;
    } ctx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // Word written to every context during the frame-start clear
    localparam logic [RAM_W-1:0] INIT_WORD = {A_W'(A_INIT), {B_W{1'b0}}, {C_W{1'b0}}, N_W'(1)};

    function automatic logic [RAM_W-1:0] ctx_pack(input ctx_t c);
        logic [RAM_W-1:0] w;
        w = '0;
        w[A_LSB +: A_W] = c.a;
        w[B_LSB +: B_W] = c.b;
        w[C_LSB +: C_W] = c.c;
        w[N_LSB +: N_W] = c.n;
        return w;
    endfunction

    function automatic ctx_t ctx_unpack(input logic [RAM_W-1:0] w);
        ctx_t c;
        c.a = w[A_LSB +: A_W];
        c.b = w[B_LSB +: B_W];
        c.c = w[C_LSB +: C_W];
        c.n = w[N_LSB +: N_W];
        return c;
    endfunction

endpackage

// File: rtl/context_sched_if.sv
// Bus bundle around the scheduler: upstream pixel handshake, stage-4 context
// and update lanes, and the external context RAM ports.
interface context_sched_if;
    import loco_pkg::*;

    // upstream context-quantisation handshake
    logic             q_valid;
    logic [Q_W-1:0]   q_in;
    logic             q_last;
    logic             ready;

    // stage-4 context out / update in
    logic             ctx_valid;
    logic [A_W-1:0]   A_Q;
    logic [B_W-1:0]   B_Q;
    logic [C_W-1:0]   C_Q;
    logic [N_W-1:0]   N_Q;
    logic [A_W-1:0]   upd_A;
    logic [B_W-1:0]   upd_B;
    logic [C_W-1:0]   upd_C;
    logic [N_W-1:0]   upd_N;

    // external context RAM
    logic             ram_re;
    logic [Q_W-1:0]   ram_raddr;
    logic [RAM_W-1:0] ram_rdata;
    logic             ram_we;
    logic [Q_W-1:0]   ram_waddr;
    logic [RAM_W-1:0] ram_wdata;

    // scheduler side
    modport master (
        input  q_valid, q_in, q_last, upd_A, upd_B, upd_C, upd_N, ram_rdata,
        output ready, ctx_valid, A_Q, B_Q, C_Q, N_Q,
               ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata
    );

    // environment side: upstream stage, stage 4 and the RAM
    modport slave (
        output q_valid, q_in, q_last, upd_A, upd_B, upd_C, upd_N, ram_rdata,
        input  ready, ctx_valid, A_Q, B_Q, C_Q, N_Q,
               ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/ctx_fwd.sv
// Context selection: unpacks either the RAM read word or the forwarded update
// (back-to-back same index) and packs the stage-4 update for writeback.
module ctx_fwd
    import loco_pkg::*;
(
    input  logic             valid,
    input  logic             fwd_hit,
    input  logic [RAM_W-1:0] rdata,
    input  logic [RAM_W-1:0] fwd_data,
    input  logic [A_W-1:0]   upd_a,
    input  logic [B_W-1:0]   upd_b,
    input  logic [C_W-1:0]   upd_c,
    input  logic [N_W-1:0]   upd_n,
    output ctx_t             ctx,
    output logic [RAM_W-1:0] upd_word
);

    // Context is zero outside valid cycles; forwarded word wins on a hit
    always_comb begin
        ctx = '0;
        if (valid) begin
            ctx = fwd_hit ? ctx_unpack(fwd_data) : ctx_unpack(rdata);
        end
    end

    // Pack the stage-4 update lanes into a RAM word
    always_comb begin
        ctx_t upd;
        upd.a    = upd_a;
        upd.b    = upd_b;
        upd.c    = upd_c;
        upd.n    = upd_n;
        upd_word = ctx_pack(upd);
    end

endmodule

// File: rtl/context_sched.sv
// Per-context state sequencer: clears the context RAM at frame start, then
// reads one context per pixel, presents it to stage 4 a cycle later and
// writes the update back, forwarding it when the next pixel uses the same index.
module context_sched
    import loco_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    context_sched_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            q_err
);

    state_t           state_reg, state_next;
    logic [Q_W-1:0]   cnt_reg, cnt_next;
    logic [Q_W-1:0]   p1_reg;
    logic             p1_valid_reg;
    logic             fwd_hit_reg;
    logic [RAM_W-1:0] fwd_data_reg;
    logic             q_err_reg;
    logic             accept;
    ctx_t             ctx;
    logic [RAM_W-1:0] upd_word;

    assign accept = (state_reg == ST_RUN) && bus.q_valid;

    ctx_fwd u_ctx_fwd (
        .valid    (p1_valid_reg),
        .fwd_hit  (fwd_hit_reg),
        .rdata    (bus.ram_rdata),
        .fwd_data (fwd_data_reg),
        .upd_a    (bus.upd_A),
        .upd_b    (bus.upd_B),
        .upd_c    (bus.upd_C),
        .upd_n    (bus.upd_N),
        .ctx      (ctx),
        .upd_word (upd_word)
    );

    // FSM state and clear-address counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: clear runs exactly NUM_CTX cycles, drain ends once the last writeback is out
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            ST_INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == Q_W'(NUM_CTX - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && bus.q_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!p1_valid_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Read/writeback pipeline, forward register and sticky range error
    always_ff @(posedge clk) begin
        if (!reset) begin
            p1_reg       <= '0;
            p1_valid_reg <= 1'b0;
            fwd_hit_reg  <= 1'b0;
            fwd_data_reg <= '0;
            q_err_reg    <= 1'b0;
        end else begin
            p1_valid_reg <= accept;
            if (accept) begin
                p1_reg <= bus.q_in;
            end
            // a hit means the word being read now is stale: it is written this very cycle
            fwd_hit_reg <= accept && p1_valid_reg && (bus.q_in == p1_reg);
            if (p1_valid_reg) begin
                fwd_data_reg <= upd_word;
            end
            if (state_reg == ST_IDLE && start) begin
                q_err_reg <= 1'b0;
            end else if (accept && (bus.q_in >= Q_W'(NUM_CTX))) begin
                q_err_reg <= 1'b1;
            end
        end
    end

    // Output decode: clear writes take the RAM port in INIT, writebacks in RUN/DRAIN
    always_comb begin
        bus.ready     = (state_reg == ST_RUN);
        bus.ram_re    = accept;
        bus.ram_raddr = accept ? bus.q_in : '0;
        bus.ram_we    = 1'b0;
        bus.ram_waddr = '0;
        bus.ram_wdata = '0;
        if (state_reg == ST_INIT) begin
            bus.ram_we    = 1'b1;
            bus.ram_waddr = cnt_reg;
            bus.ram_wdata = INIT_WORD;
        end else if (p1_valid_reg) begin
            bus.ram_we    = 1'b1;
            bus.ram_waddr = p1_reg;
            bus.ram_wdata = upd_word;
        end
        bus.ctx_valid = p1_valid_reg;
        bus.A_Q       = ctx.a;
        bus.B_Q       = ctx.b;
        bus.C_Q       = ctx.c;
        bus.N_Q       = ctx.n;
        busy          = (state_reg != ST_IDLE);
        done          = (state_reg == ST_DRAIN) && !p1_valid_reg;
        q_err         = q_err_reg;
    end

endmodule

// File: tb/tb_context_sched.sv
// Scoreboard bench for context_sched: a behavioural context store (one entry
// per index, updated in pixel order) predicts each presented context and
// writeback; a monitor pops predictions whenever ctx_valid is seen.
`timescale 1ns/1ps
module tb_context_sched;
    import loco_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done, q_err;

    context_sched_if bus ();

    context_sched dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .q_err (q_err)
    );

    always #5 clk = ~clk;

    // External synchronous RAM, old data on read-during-write
    logic [RAM_W-1:0] mem [0:511];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    // Stage-4 stub: A += delta, B += 1, C -= 1, N += 1 (field-width wrap)
    int unsigned delta = 1;
    assign bus.upd_A = bus.A_Q + A_W'(delta);
    assign bus.upd_B = bus.B_Q + 7'd1;
    assign bus.upd_C = bus.C_Q - 8'd1;
    assign bus.upd_N = bus.N_Q + 7'd1;

    // Reference context store
    int ref_a [512];
    int ref_b [512];
    int ref_c [512];
    int ref_n [512];
    bit exp_qerr;

    typedef struct {
        int q;
        int a;
        int b;
        int c;
        int n;
        logic [RAM_W-1:0] wd;
    } exp_t;
    exp_t sb [$];
    exp_t mon_e;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every ctx_valid cycle must match the oldest prediction
    always @(negedge clk) begin
        if (reset) begin
            if (bus.ctx_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_ctx_valid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("A_Q", bus.A_Q, mon_e.a);
                    check("B_Q", bus.B_Q, mon_e.b);
                    check("C_Q", bus.C_Q, mon_e.c);
                    check("N_Q", bus.N_Q, mon_e.n);
                    check("wb_we", bus.ram_we, 1);
                    check("wb_addr", bus.ram_waddr, mon_e.q);
                    check("wb_data", bus.ram_wdata, mon_e.wd);
                    $display("pixel q=%0d A=%0d B=%0d C=%0d N=%0d", mon_e.q, bus.A_Q, bus.B_Q, bus.C_Q, bus.N_Q);
                end
            end else begin
                check("ctx_idle_zero", {bus.A_Q, bus.B_Q, bus.C_Q, bus.N_Q}, 0);
            end
        end
    end

    task automatic send(input int q, input bit last);
        exp_t e;
        int na, nb, nc, nn;
        @(negedge clk);
        bus.q_valid = 1'b1;
        bus.q_in    = Q_W'(q);
        bus.q_last  = last;
        check("ready_on_send", bus.ready, 1);
        e.q = q;
        e.a = ref_a[q];
        e.b = ref_b[q];
        e.c = ref_c[q];
        e.n = ref_n[q];
        na = (e.a + int'(delta)) % 8192;
        nb = (e.b + 1) % 128;
        nc = (e.c + 255) % 256;
        nn = (e.n + 1) % 128;
        e.wd = {A_W'(na), B_W'(nb), C_W'(nc), N_W'(nn)};
        sb.push_back(e);
        ref_a[q] = na;
        ref_b[q] = nb;
        ref_c[q] = nc;
        ref_n[q] = nn;
        if (q >= 365) exp_qerr = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.q_valid = 1'b0;
        bus.q_last  = 1'b0;
    endtask

    task automatic clear_ram();
        int wcount = 0;
        int rise = -1;
        bit ok_addr = 1'b1;
        bit ok_data = 1'b1;
        logic [RAM_W-1:0] init_w;
        init_w = {13'd4, 7'd0, 8'd0, 7'd1};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_qerr = 1'b0;
        check("q_err_after_start", q_err, 0);
        check("busy_init", busy, 1);
        for (int i = 0; i < 400; i++) begin
            if (bus.ready) begin
                rise = i;
                break;
            end
            if (bus.ram_we) begin
                if (int'(bus.ram_waddr) != wcount) ok_addr = 1'b0;
                if (bus.ram_wdata != init_w) ok_data = 1'b0;
                wcount++;
            end
            if (i == 50) bus.q_valid = 1'b1;   // ignored during clear
            if (i == 51) bus.q_valid = 1'b0;
            @(negedge clk);
        end
        check("init_write_count", wcount, 365);
        check("init_addr_seq", ok_addr, 1);
        check("init_data", ok_data, 1);
        check("ready_rise_cycle", rise, 365);
        for (int q = 0; q < 365; q++) begin
            ref_a[q] = 4;
            ref_b[q] = 0;
            ref_c[q] = 0;
            ref_n[q] = 1;
        end
        $display("clear done writes=%0d ready_cycle=%0d", wcount, rise + 1);
    endtask

    task automatic end_frame();
        int bad = 0;
        @(negedge clk);
        bus.q_valid = 1'b0;
        bus.q_last  = 1'b0;
        check("drain_done_low", done, 0);
        check("drain_busy", busy, 1);
        check("drain_ready_low", bus.ready, 0);
        @(negedge clk);
        check("done_pulse", done, 1);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("idle_busy", busy, 0);
        check("idle_ready", bus.ready, 0);
        check("q_err_sticky", q_err, exp_qerr);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.q_valid = 1'b1;
            bus.q_in    = Q_W'($urandom_range(0, 364));
            #1;
            check("ram_re_idle", bus.ram_re, 0);
        end
        @(negedge clk);
        bus.q_valid = 1'b0;
        check("sb_empty", sb.size(), 0);
        for (int q = 0; q < 512; q++) begin
            if (mem[q] != {A_W'(ref_a[q]), B_W'(ref_b[q]), C_W'(ref_c[q]), N_W'(ref_n[q])}) bad++;
        end
        check("ram_contents", bad, 0);
        $display("frame end done ok, ram mismatches=%0d", bad);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.ready, 0);
        check({tag, "_ctx_valid"}, bus.ctx_valid, 0);
        check({tag, "_ctx"}, {bus.A_Q, bus.B_Q, bus.C_Q, bus.N_Q}, 0);
        check({tag, "_ram_re"}, {bus.ram_re, bus.ram_raddr}, 0);
        check({tag, "_ram_we"}, {bus.ram_we, bus.ram_waddr, bus.ram_wdata}, 0);
        check({tag, "_status"}, {busy, done, q_err}, 0);
    endtask

    initial begin
        bit found;
        int n;
        int q;
        bus.q_valid = 1'b0;
        bus.q_in    = '0;
        bus.q_last  = 1'b0;
        for (int i = 0; i < 512; i++) begin
            mem[i]   = '0;
            ref_a[i] = 0;
            ref_b[i] = 0;
            ref_c[i] = 0;
            ref_n[i] = 0;
        end
        exp_qerr = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // distinct indices
        delta = 1;
        clear_ram();
        send(5, 0);
        send(9, 0);
        send(12, 0);
        send(3, 1);
        end_frame();
        check("ram5_A", mem[5][34:22], 5);
        check("ram9_A", mem[9][34:22], 5);
        check("ram12_A", mem[12][34:22], 5);

        // back-to-back hits on one index
        delta = 3;
        clear_ram();
        send(7, 0);
        send(7, 0);
        send(7, 1);
        end_frame();
        check("ram7_A_b2b", mem[7][34:22], 13);

        // same index with one idle cycle between
        clear_ram();
        send(7, 0);
        idle_cycle();
        send(7, 1);
        end_frame();
        check("ram7_A_gap1", mem[7][34:22], 10);

        // out-of-range index
        delta = 2;
        clear_ram();
        send(400, 0);
        send(2, 1);
        end_frame();
        check("q_err_set", q_err, 1);

        // reset in the middle of the clear
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.ram_we && bus.ram_waddr == 9'd100) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_addr_100", found, 1);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midinit");
        reset = 1'b1;
        $display("reset mid-clear applied");
        clear_ram();
        send(1, 1);
        end_frame();

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            delta = $urandom_range(1, 7);
            clear_ram();
            n = $urandom_range(5, 40);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                case ($urandom_range(0, 9))
                    0:       q = $urandom_range(365, 511);
                    1, 2, 3: q = $urandom_range(0, 364);
                    default: q = $urandom_range(0, 5);
                endcase
                send(q, k == n - 1);
            end
            end_frame();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
